edge_to_level: RTL and testbench

- Reconstructs a level waveform from single-cycle rise/fall event pulses. It is the inverse of the edge detector.
- Sits downstream of event sources such as edge detectors, decoded commands or remote toggles, and drives a clean registered level.
- Enforces a minimum dwell time between transitions.
- Flags conflicting or discarded events.

---
 rtl/edge_to_level_if.sv | 12 +
 rtl/edge_to_level.sv | 67 ++++++
 tb/tb_edge_to_level.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/edge_to_level_if.sv
// edge_to_level_if: event inputs and level/status outputs of edge_to_level
interface edge_to_level_if;
  logic rise_i;
  logic fall_i;
  logic level_o;
  logic busy_o;
  logic pending_o;
  logic drop_o;
  logic conflict_o;
  modport master(output rise_i, fall_i, input level_o, busy_o, pending_o, drop_o, conflict_o);
  modport slave(input rise_i, fall_i, output level_o, busy_o, pending_o, drop_o, conflict_o);
endinterface

// File: rtl/edge_to_level.sv
// edge_to_level: rebuilds a level from rise/fall pulses with a minimum dwell time.
// EDGE_TO_LEVEL_PENDING_EN defers events seen during dwell instead of dropping them.
module edge_to_level #(
  parameter int   MIN_HOLD    = 4,
  parameter logic RESET_LEVEL = 1'b0
) (
  input logic            clk,
  input logic            reset_n,
  edge_to_level_if.slave bus
);
  localparam int CW = MIN_HOLD > 1 ? $clog2(MIN_HOLD) : 1;
  localparam logic [CW-1:0] LOAD = CW'(MIN_HOLD - 1);
`ifdef EDGE_TO_LEVEL_PENDING_EN
  typedef enum logic [1:0] {IDLE, HOLD, HOLD_PEND} state_t;
  localparam bit PEND_EN = 1'b1;
`else
  typedef enum logic {IDLE, HOLD} state_t;
  localparam bit PEND_EN = 1'b0;
`endif
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          level, level_nx, drop, drop_nx, conflict, conflict_nx;
  logic          pend, pend_nx, ev, valid, redundant, expired, apply;
`ifdef EDGE_TO_LEVEL_PENDING_EN
  assign pend = state == HOLD_PEND;
`else
  assign pend = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      level    <= RESET_LEVEL;
      drop     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      level    <= level_nx;
      drop     <= drop_nx;
      conflict <= conflict_nx;
    end
  end
  // A simultaneous rise/fall is no event at all; dwell and pending timing carry on.
  always_comb begin
    conflict_nx = bus.rise_i & bus.fall_i;
    ev          = bus.rise_i ^ bus.fall_i;
    valid       = ev && (bus.rise_i != level);
    redundant   = ev && (bus.rise_i == level);
    expired     = cnt == '0;
    apply       = expired && (pend ? !redundant : valid);
    level_nx    = apply ? ~level : level;
    cnt_nx      = apply ? LOAD : expired ? cnt : cnt - 1'b1;
    pend_nx     = PEND_EN && !expired && (valid || (pend && !redundant));
    drop_nx     = !PEND_EN && !expired && valid;
`ifdef EDGE_TO_LEVEL_PENDING_EN
    state_nx    = pend_nx ? HOLD_PEND : cnt_nx != '0 ? HOLD : IDLE;
`else
    state_nx    = cnt_nx != '0 ? HOLD : IDLE;
`endif
  end
  assign bus.level_o    = level;
  assign bus.busy_o     = cnt != '0;
  assign bus.pending_o  = pend;
  assign bus.drop_o     = drop;
  assign bus.conflict_o = conflict;
endmodule

// File: tb/tb_edge_to_level.sv
// tb_edge_to_level: randomized and directed checks of edge_to_level against a dwell-time model
module tb_edge_to_level;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic m_lvl, m_pend, m_drop, m_conf;
  int   m_since;

  edge_to_level_if b1();
  edge_to_level_if b2();
  edge_to_level #(.MIN_HOLD(MH), .RESET_LEVEL(1'b0)) dut  (.clk(clk), .reset_n(reset_n), .bus(b1));
  edge_to_level #(.MIN_HOLD(1),  .RESET_LEVEL(1'b0)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b2));

  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {b1.level_o, b1.busy_o, b1.pending_o, b1.drop_o, b1.conflict_o};
  endfunction

  // Model works from elapsed edges since the last transition, not a down-counter.
  function automatic logic [4:0] expv();
    return {m_lvl, m_since < MH - 1, m_pend, m_drop, m_conf};
  endfunction

  task automatic model_reset();
    m_lvl = 1'b0; m_pend = 1'b0; m_drop = 1'b0; m_conf = 1'b0; m_since = MH;
  endtask

  task automatic model_step(input logic r, input logic f);
    int   s;
    logic ev, tgt;
    s = (m_since > 1000) ? 1000 : m_since + 1;
    ev = r ^ f;
    m_conf = r & f;
    m_drop = 1'b0;
    if (s >= MH) begin
      tgt = ev ? r : (m_pend ? ~m_lvl : m_lvl);
      if (tgt != m_lvl) begin m_lvl = tgt; s = 0; end
      m_pend = 1'b0;
    end else if (ev) begin
      if (r != m_lvl) begin
`ifdef EDGE_TO_LEVEL_PENDING_EN
        m_pend = 1'b1;
`else
        m_drop = 1'b1;
`endif
      end else m_pend = 1'b0;
    end
    m_since = s;
  endtask

  task automatic drive(input logic r, input logic f);
    @(negedge clk);
    b1.rise_i = r;
    b1.fall_i = f;
    @(posedge clk);
    model_step(r, f);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    b1.rise_i = 1'b0; b1.fall_i = 1'b0; b2.rise_i = 1'b0; b2.fall_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 5'b0) begin errors++; $display("FAIL reset: got %b exp 00000", obs()); end
    checks++;
    if ({b2.level_o, b2.busy_o} !== 2'b00) begin errors++; $display("FAIL reset_mh1: got %b exp 00", {b2.level_o, b2.busy_o}); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    logic [1:0] seq [10] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    foreach (seq[i]) begin
      drive(seq[i][1], seq[i][0]);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL basic[%0d]: got %b exp %b", i, obs(), expv()); end
    end
  endtask

  task automatic test_dwell_event();
    logic [1:0] seq [16] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                             2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    foreach (seq[i]) begin
      drive(seq[i][1], seq[i][0]);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL dwell[%0d]: got %b exp %b", i, obs(), expv()); end
    end
  endtask

  task automatic test_expiry_edge();
    logic [1:0] seq [14] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00,
                             2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
    foreach (seq[i]) begin
      drive(seq[i][1], seq[i][0]);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL expiry[%0d]: got %b exp %b", i, obs(), expv()); end
    end
  endtask

  task automatic test_conflict();
    logic [1:0] seq [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00};
    foreach (seq[i]) begin
      drive(seq[i][1], seq[i][0]);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL conflict[%0d]: got %b exp %b", i, obs(), expv()); end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL pre_areset: got %b exp %b", obs(), expv()); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 5'b0) begin errors++; $display("FAIL async_reset: got %b exp 00000", obs()); end
    @(negedge clk);
    reset_n = 1'b1;
    b1.fall_i = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      drive(i == 0, 1'b0);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL after_areset[%0d]: got %b exp %b", i, obs(), expv()); end
    end
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 400; i++) begin
      v = $urandom_range(0, 11);
      drive(v inside {0, 1, 2, 9}, v inside {3, 4, 5, 9});
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL random[%0d]: got %b exp %b", i, obs(), expv()); end
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic test_min_hold1();
    logic exp_l;
    exp_l = b2.level_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b2.rise_i = ~exp_l;
      b2.fall_i = exp_l;
      exp_l = ~exp_l;
      @(posedge clk);
      #1;
      checks++;
      if ({b2.level_o, b2.busy_o, b2.drop_o} !== {exp_l, 2'b00}) begin
        errors++;
        $display("FAIL min_hold1[%0d]: got %b exp %b", i, {b2.level_o, b2.busy_o, b2.drop_o}, {exp_l, 2'b00});
      end
    end
    @(negedge clk);
    b2.rise_i = 1'b0;
    b2.fall_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dwell_event();
    test_expiry_edge();
    test_conflict();
    test_async_reset();
    test_random();
    test_min_hold1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
